// File: rtl/mem_arbiter_if.sv
// Request, response and RAM-port signals shared between mem_arbiter and its environment.
// The slave modport is the arbiter's view; master is the view of whoever drives it.
interface mem_arbiter_if #(
  parameter int W = 64
);
  logic          i_if_req;
  logic [W-1:0]  i_if_pc;
  logic          o_if_gnt;
  logic          o_if_rvalid;
  logic [31:0]   o_if_ins;
  logic          o_if_err;

  logic          i_ls_req;
  logic          i_ls_wen;
  logic [W-1:0]  i_ls_addr;
  logic [W-1:0]  i_ls_wdata;
  logic [W-1:0]  i_ls_wmask;
  logic          o_ls_gnt;
  logic          o_ls_rvalid;
  logic [W-1:0]  o_ls_rdata;
  logic          o_ls_err;

  logic          o_ram_en;
  logic [W-1:0]  o_ram_ridx;
  logic [W-1:0]  i_ram_rdata;
  logic [W-1:0]  o_ram_widx;
  logic [W-1:0]  o_ram_wdata;
  logic [W-1:0]  o_ram_wmask;
  logic          o_ram_wen;

  modport slave (
    input  i_if_req, i_if_pc,
    output o_if_gnt, o_if_rvalid, o_if_ins, o_if_err,
    input  i_ls_req, i_ls_wen, i_ls_addr, i_ls_wdata, i_ls_wmask,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
    output o_ram_en, o_ram_ridx, o_ram_widx, o_ram_wdata, o_ram_wmask, o_ram_wen,
    input  i_ram_rdata
  );

  modport master (
    output i_if_req, i_if_pc,
    input  o_if_gnt, o_if_rvalid, o_if_ins, o_if_err,
    output i_ls_req, i_ls_wen, i_ls_addr, i_ls_wdata, i_ls_wmask,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata, o_ls_err,
    input  o_ram_en, o_ram_ridx, o_ram_widx, o_ram_wdata, o_ram_wmask, o_ram_wen,
    output i_ram_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store, LSU-first with an
// IF starvation guard; each grant is answered exactly one cycle later from the owner register.
module mem_arbiter #(
  parameter int              CPU_WIDTH    = 64,
  parameter logic [63:0]     PC_START     = 64'h8000_0000,
  parameter int              STARVE_LIMIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

  localparam logic [3:0]           LIMIT = 4'(STARVE_LIMIT);
  localparam logic [CPU_WIDTH-1:0] BASE  = CPU_WIDTH'(PC_START);

  owner_t               r_owner;
  logic [3:0]           r_starve_cnt;
  logic                 r_fault;
  logic                 r_pc2;
  logic                 r_wen;

  owner_t               w_owner_next;
  logic [3:0]           w_starve_next;
  logic                 w_fault_next;
  logic                 w_if_gnt;
  logic                 w_ls_gnt;
  logic                 w_if_fault;
  logic                 w_ls_fault;
  logic [CPU_WIDTH-1:0] w_addr;
  logic [CPU_WIDTH-1:0] w_idx;

  assign w_if_fault = (bus.i_if_pc < BASE) || (bus.i_if_pc[1:0] != 2'b00);
  assign w_ls_fault = (bus.i_ls_addr < BASE);
  assign w_addr     = w_if_gnt ? bus.i_if_pc : bus.i_ls_addr;
  assign w_idx      = (w_addr - BASE) >> 3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner      <= OWN_NONE;
      r_starve_cnt <= '0;
      r_fault      <= 1'b0;
      r_pc2        <= 1'b0;
      r_wen        <= 1'b0;
    end else begin
      r_owner      <= w_owner_next;
      r_starve_cnt <= w_starve_next;
      r_fault      <= w_fault_next;
      r_pc2        <= w_if_gnt & bus.i_if_pc[2];
      r_wen        <= w_ls_gnt & bus.i_ls_wen;
    end
  end

  always_comb begin
    w_if_gnt      = 1'b0;
    w_ls_gnt      = 1'b0;
    w_starve_next = '0;
    w_owner_next  = OWN_NONE;
    w_fault_next  = 1'b0;

    // Contested cycles let LSU win until IF has lost LIMIT times in a row.
    if (bus.i_ls_req && bus.i_if_req) begin
      if (r_starve_cnt < LIMIT) begin
        w_ls_gnt      = 1'b1;
        w_starve_next = r_starve_cnt + 4'd1;
      end else begin
        w_if_gnt      = 1'b1;
      end
    end else if (bus.i_ls_req) begin
      w_ls_gnt = 1'b1;
    end else if (bus.i_if_req) begin
      w_if_gnt = 1'b1;
    end

    if (w_if_gnt) begin
      w_owner_next = OWN_IF;
      w_fault_next = w_if_fault;
    end else if (w_ls_gnt) begin
      w_owner_next = OWN_LS;
      w_fault_next = w_ls_fault;
    end
  end

  assign bus.o_if_gnt    = w_if_gnt;
  assign bus.o_ls_gnt    = w_ls_gnt;
  assign bus.o_ram_en    = (w_if_gnt && !w_if_fault) ||
                           (w_ls_gnt && !bus.i_ls_wen && !w_ls_fault);
  assign bus.o_ram_wen   = w_ls_gnt && bus.i_ls_wen && !w_ls_fault;
  assign bus.o_ram_ridx  = w_idx;
  assign bus.o_ram_widx  = w_idx;
  assign bus.o_ram_wdata = bus.i_ls_wdata;
  assign bus.o_ram_wmask = bus.i_ls_wmask;

  always_comb begin
    bus.o_if_rvalid = (r_owner == OWN_IF);
    bus.o_if_err    = (r_owner == OWN_IF) && r_fault;
    bus.o_ls_rvalid = (r_owner == OWN_LS);
    bus.o_ls_err    = (r_owner == OWN_LS) && r_fault;
    bus.o_if_ins    = '0;
    bus.o_ls_rdata  = '0;
    if (r_owner == OWN_IF && !r_fault) begin
      bus.o_if_ins = r_pc2 ? bus.i_ram_rdata[CPU_WIDTH-1:CPU_WIDTH-32] : bus.i_ram_rdata[31:0];
    end
    if (r_owner == OWN_LS && !r_fault && !r_wen) begin
      bus.o_ls_rdata = bus.i_ram_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small registered-read RAM model behind the RAM port.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   fail_cnt;
  int   total_cnt;

  mem_arbiter_if #(.W(64)) bus ();

  mem_arbiter #(
    .CPU_WIDTH(64), .PC_START(64'h8000_0000), .STARVE_LIMIT(4)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] mem [0:15];

  // RAM model: preloaded while in reset, registered read, masked write.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'h0;
      mem[0] <= 64'hCAFE_0004_CAFE_0000;
      mem[1] <= 64'hCAFE_000C_CAFE_0008;
      bus.i_ram_rdata <= 64'h0;
    end else begin
      if (bus.o_ram_wen)
        mem[bus.o_ram_widx[3:0]] <= (mem[bus.o_ram_widx[3:0]] & ~bus.o_ram_wmask) |
                                    (bus.o_ram_wdata & bus.o_ram_wmask);
      if (bus.o_ram_en)
        bus.i_ram_rdata <= mem[bus.o_ram_ridx[3:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic if_g, input logic ls_g);
    chk({tag, ".if_gnt"}, {63'h0, bus.o_if_gnt}, {63'h0, if_g});
    chk({tag, ".ls_gnt"}, {63'h0, bus.o_ls_gnt}, {63'h0, ls_g});
  endtask

  task automatic set_if(input logic req, input logic [63:0] pc);
    bus.i_if_req = req;
    bus.i_if_pc  = pc;
  endtask

  task automatic set_ls(input logic req, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] wmask);
    bus.i_ls_req   = req;
    bus.i_ls_wen   = wen;
    bus.i_ls_addr  = addr;
    bus.i_ls_wdata = wdata;
    bus.i_ls_wmask = wmask;
  endtask

  initial begin
    pass_cnt = 0;
    fail_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    set_if(1'b0, 64'h0);
    set_ls(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);

    next_cycle();
    next_cycle();
    chk("rst.if_rvalid", {63'h0, bus.o_if_rvalid}, 64'h0);
    chk("rst.ls_rvalid", {63'h0, bus.o_ls_rvalid}, 64'h0);
    chk("rst.ram_en",    {63'h0, bus.o_ram_en},    64'h0);
    chk("rst.ram_wen",   {63'h0, bus.o_ram_wen},   64'h0);
    chk("rst.if_ins",    {32'h0, bus.o_if_ins},    64'h0);
    chk("rst.ls_rdata",  bus.o_ls_rdata,           64'h0);
    rst_n = 1'b1;
    next_cycle();

    // IF alone at pc ...04 then ...08.
    set_if(1'b1, 64'h8000_0004);
    #2;
    chk_gnt("if04", 1'b1, 1'b0);
    chk("if04.ram_en", {63'h0, bus.o_ram_en}, 64'h1);
    chk("if04.ridx", bus.o_ram_ridx, 64'h0);
    next_cycle();
    set_if(1'b1, 64'h8000_0008);
    #2;
    chk("if04.rvalid", {63'h0, bus.o_if_rvalid}, 64'h1);
    chk("if04.ins", {32'h0, bus.o_if_ins}, 64'hCAFE_0004);
    chk("if04.err", {63'h0, bus.o_if_err}, 64'h0);
    chk("if08.ridx", bus.o_ram_ridx, 64'h1);
    next_cycle();
    set_if(1'b0, 64'h0);
    #2;
    chk("if08.ins", {32'h0, bus.o_if_ins}, 64'hCAFE_0008);
    next_cycle();
    #2;
    chk("idle.if_rvalid", {63'h0, bus.o_if_rvalid}, 64'h0);
    chk("idle.if_ins", {32'h0, bus.o_if_ins}, 64'h0);

    // Back-to-back IF fetches.
    set_if(1'b1, 64'h8000_0000);
    next_cycle();
    set_if(1'b1, 64'h8000_0004);
    #2;
    chk("b2b0.ins", {32'h0, bus.o_if_ins}, 64'hCAFE_0000);
    next_cycle();
    set_if(1'b1, 64'h8000_0008);
    #2;
    chk("b2b1.rvalid", {63'h0, bus.o_if_rvalid}, 64'h1);
    chk("b2b1.ins", {32'h0, bus.o_if_ins}, 64'hCAFE_0004);
    next_cycle();
    set_if(1'b0, 64'h0);
    #2;
    chk("b2b2.rvalid", {63'h0, bus.o_if_rvalid}, 64'h1);
    chk("b2b2.ins", {32'h0, bus.o_if_ins}, 64'hCAFE_0008);
    next_cycle();

    // LSU write, partial-mask write, read back.
    set_ls(1'b1, 1'b1, 64'h8000_0010, 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF);
    #2;
    chk_gnt("wr", 1'b0, 1'b1);
    chk("wr.ram_wen", {63'h0, bus.o_ram_wen}, 64'h1);
    chk("wr.ram_en", {63'h0, bus.o_ram_en}, 64'h0);
    chk("wr.widx", bus.o_ram_widx, 64'h2);
    chk("wr.wdata", bus.o_ram_wdata, 64'hDEAD_BEEF);
    next_cycle();
    set_ls(1'b1, 1'b1, 64'h8000_0010, 64'h1234_5678_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
    #2;
    chk("wr.ack", {63'h0, bus.o_ls_rvalid}, 64'h1);
    chk("wr.rdata", bus.o_ls_rdata, 64'h0);
    chk("wr2.wmask", bus.o_ram_wmask, 64'hFFFF_FFFF_0000_0000);
    next_cycle();
    set_ls(1'b1, 1'b0, 64'h8000_0010, 64'h0, 64'h0);
    #2;
    chk("rd.ram_en", {63'h0, bus.o_ram_en}, 64'h1);
    chk("rd.ridx", bus.o_ram_ridx, 64'h2);
    next_cycle();
    set_ls(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    #2;
    chk("rd.rvalid", {63'h0, bus.o_ls_rvalid}, 64'h1);
    chk("rd.rdata", bus.o_ls_rdata, 64'h1234_5678_DEAD_BEEF);
    next_cycle();

    // Faults: misaligned IF, below-base LSU write and read.
    set_if(1'b1, 64'h8000_0002);
    #2;
    chk_gnt("iffault", 1'b1, 1'b0);
    chk("iffault.ram_en", {63'h0, bus.o_ram_en}, 64'h0);
    next_cycle();
    set_if(1'b0, 64'h0);
    set_ls(1'b1, 1'b1, 64'h7FFF_FFF8, 64'h5555, 64'hFFFF_FFFF_FFFF_FFFF);
    #2;
    chk("iffault.err", {63'h0, bus.o_if_err}, 64'h1);
    chk("iffault.ins", {32'h0, bus.o_if_ins}, 64'h0);
    chk_gnt("lsfault_wr", 1'b0, 1'b1);
    chk("lsfault_wr.ram_wen", {63'h0, bus.o_ram_wen}, 64'h0);
    next_cycle();
    set_ls(1'b1, 1'b0, 64'h7FFF_FFF8, 64'h0, 64'h0);
    #2;
    chk("lsfault_wr.err", {63'h0, bus.o_ls_err}, 64'h1);
    chk("lsfault_rd.ram_en", {63'h0, bus.o_ram_en}, 64'h0);
    next_cycle();
    set_ls(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    #2;
    chk("lsfault_rd.err", {63'h0, bus.o_ls_err}, 64'h1);
    chk("lsfault_rd.rdata", bus.o_ls_rdata, 64'h0);
    next_cycle();

    // Continuous contention: LS x4 then IF, repeating.
    set_if(1'b1, 64'h8000_0000);
    set_ls(1'b1, 1'b0, 64'h8000_0008, 64'h0, 64'h0);
    for (int k = 0; k < 10; k++) begin
      #2;
      chk_gnt($sformatf("starve%0d", k), (k % 5) == 4, (k % 5) != 4);
      if (k > 0) begin
        if (((k - 1) % 5) == 4) begin
          chk($sformatf("starve%0d.if_rvalid", k - 1), {63'h0, bus.o_if_rvalid}, 64'h1);
          chk($sformatf("starve%0d.ins", k - 1), {32'h0, bus.o_if_ins}, 64'hCAFE_0000);
        end else begin
          chk($sformatf("starve%0d.ls_rvalid", k - 1), {63'h0, bus.o_ls_rvalid}, 64'h1);
          chk($sformatf("starve%0d.rdata", k - 1), bus.o_ls_rdata, 64'hCAFE_000C_CAFE_0008);
        end
      end
      next_cycle();
    end
    set_if(1'b0, 64'h0);
    set_ls(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    #2;
    chk("starve9.if_rvalid", {63'h0, bus.o_if_rvalid}, 64'h1);
    chk("starve9.ls_rvalid", {63'h0, bus.o_ls_rvalid}, 64'h0);
    next_cycle();

    // Reset in a response cycle after two contested LSU grants.
    set_if(1'b1, 64'h8000_0000);
    set_ls(1'b1, 1'b0, 64'h8000_0008, 64'h0, 64'h0);
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst.ls_rvalid", {63'h0, bus.o_ls_rvalid}, 64'h0);
    chk("midrst.if_rvalid", {63'h0, bus.o_if_rvalid}, 64'h0);
    chk("midrst.ls_rdata", bus.o_ls_rdata, 64'h0);
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk_gnt($sformatf("postrst%0d", k), k == 4, k != 4);
      next_cycle();
    end
    set_if(1'b0, 64'h0);
    set_ls(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    next_cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAMHelper-style memory port between the instruction fetch path (read-only, 32-bit instructions) and the load/store path (64-bit read/write with byte mask).
- Sits between ifu/lsu and the RAM wrapper. Arbitrates one request per cycle with LSU priority and a starvation guard for IF.
- Translates byte addresses to 64-bit word indices: (addr - PC_START) >> 3.
- Returns responses exactly one cycle after grant.

Parameters:
- CPU_WIDTH, 64, address and data width.
- PC_START, 64'h8000_0000, base byte address of RAM.
- STARVE_LIMIT, 4, maximum consecutive contested LSU grants before IF is forced to win. Legal range 1..15.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_if_req  in  1  IF read request (level; held until granted)
- i_if_pc  in  64  IF byte address
- o_if_gnt  out  1  IF request accepted this cycle
- o_if_rvalid  out  1  IF response valid (one-cycle pulse)
- o_if_ins  out  32  instruction; pc[2] ? word[63:32] : word[31:0]
- o_if_err  out  1  IF access fault, qualified by o_if_rvalid
- i_ls_req  in  1  LSU request (level; held until granted)
- i_ls_wen  in  1  1 = write, 0 = read
- i_ls_addr  in  64  LSU byte address
- i_ls_wdata  in  64  write data
- i_ls_wmask  in  64  bit-level write mask
- o_ls_gnt  out  1  LSU request accepted this cycle
- o_ls_rvalid  out  1  LSU response/ack (one-cycle pulse)
- o_ls_rdata  out  64  read data
- o_ls_err  out  1  LSU access fault, qualified by o_ls_rvalid
- o_ram_en  out  1  RAM read enable
- o_ram_ridx  out  64  RAM read word index
- i_ram_rdata  in  64  RAM read data, valid one cycle after o_ram_ridx/o_ram_en
- o_ram_widx  out  64  RAM write word index
- o_ram_wdata  out  64  RAM write data
- o_ram_wmask  out  64  RAM write mask
- o_ram_wen  out  1  RAM write enable

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset state: owner=NONE, starve_cnt=0, all registered state cleared.
- Reset values of outputs: all gnt/rvalid/err/en/wen outputs are 0. Data outputs o_if_ins and o_ls_rdata are 0.
- Owner register (states NONE / IF / LS) records the requester granted in the previous cycle.

Grant (combinational, same cycle as request):
- Only LSU requesting -> LSU granted. Only IF requesting -> IF granted.
- Both requesting:
  - starve_cnt < STARVE_LIMIT -> LSU granted, starve_cnt += 1.
  - starve_cnt == STARVE_LIMIT -> IF granted, starve_cnt = 0.
- starve_cnt clears whenever IF is granted or i_if_req = 0.
- Exactly one grant per cycle, at most.
- Granting is allowed every cycle, including a response cycle, so throughput is one access per cycle.
- owner <= granted requester, or NONE if no grant.

RAM drive in grant cycle:
- ridx = widx = (addr - PC_START) >> 3, 64-bit wrap-free subtraction.
- IF grant or LSU read: o_ram_en = 1.
- LSU write: o_ram_wen = 1 with wdata/wmask passed through, and o_ram_en = 0.

Faults:
- A fault occurs when addr < PC_START, or for IF when pc[1:0] != 0.
- Faulting request: still granted, but o_ram_en = o_ram_wen = 0.
- The fault flag is registered and reported with the response.

Response (cycle after grant, selected by owner):
- owner=IF: o_if_rvalid = 1, o_if_ins selected from i_ram_rdata by the registered pc[2].
- owner=LS: o_ls_rvalid = 1. Read -> o_ls_rdata = i_ram_rdata. Write -> o_ls_rdata = 0.
- On fault: err = 1, data = 0.
- Outside a response, data outputs are forced to 0.

Boundary conditions:
- Requests that are not granted are not queued internally; the requester holds req until it sees gnt.
- Reset mid-transaction: the pending response is dropped with no rvalid. Requesters re-issue after reset.

Test Plan:
- IF only, pc=0x8000_0004 -> gnt same cycle, ridx=0; next cycle o_if_rvalid=1 and o_if_ins=rdata[63:32]. With pc=0x8000_0008 -> ridx=1, ins=rdata[31:0].
- LSU write addr=0x8000_0010, wdata=0xDEAD_BEEF, mask all-ones -> o_ram_wen=1, widx=2 in grant cycle; ack next cycle with o_ls_rdata=0. A following read of the same address returns 0xDEAD_BEEF.
- Both requesting continuously, STARVE_LIMIT=4 -> grant pattern LS,LS,LS,LS,IF repeating; each response appears exactly one cycle after its grant.
- IF pc=0x8000_0002 and LSU addr=0x7FFF_FFF8 -> no RAM enable or write; err=1, data=0 in the respective response cycles.
- Back-to-back IF grants at pc 0x8000_0000, 0x8000_0004, 0x8000_0008 -> three consecutive rvalid cycles with correct halves.
- i_rst_n dropped in the response cycle -> rvalid goes 0 immediately, starve_cnt=0. After release, the first contested grant goes to LSU.
